qkv_proj_engine: RTL and testbench
==================================

# qkv_proj_engine

Parametrised tiled INT8 projection engine, the successor to the fixed 4×4 / 32-tile Q projection path in the self-attention block. One `start` computes `OUT = A × W[mode] + bias[mode]` over run-time-free, elaboration-time-sized tile grids. Mode selects Q, K or V weights, biases and output region from shared SRAMs. It has an internal N×N MAC tile with no external systolic array, and raw INT32 results go to the output SRAM; FP32 conversion stays downstream.

## Interface
- `N`, 4: tile edge (N×N elements per tile)
- `DATA_W`, 8: signed operand width
- `ACC_W`, 32: signed accumulator/bias/output width
- `ROWS_T`, 1: row tiles of A
- `K_T`, 32: reduction tiles
- `COLS_T`, 32: output column tiles
- `IA_W`, `W_AW`, `B_AW`, `O_AW`: address widths sized for the maximum index (derived, overridable)

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request, accepted only in IDLE.
- `mode` in 2: 0=Q, 1=K, 2=V, sampled at accept. 3 is illegal: it is not accepted and raises `err` for 1 cycle.
- `busy` out 1: high from the accept cycle+1 through the done cycle.
- `done` out 1: one-cycle pulse after the last output write.
- `err` out 1: one-cycle pulse on an illegal mode.
- `in_ceb`/`in_addr`/`in_dout`: A SRAM (active-low enable, read-only; `in_dout` is N·N·DATA_W).
- `w_ceb`/`w_addr`/`w_dout`: weight SRAM (same format).
- `b_ceb`/`b_addr`/`b_dout`: bias SRAM (`b_dout` is N·ACC_W).
- `out_ceb`/`out_wen`/`out_addr`/`out_din`: output SRAM (active-low; `out_din` is N·ACC_W).

## Operation
- **Packing**
  - a[i][j] sits at `in_dout[(i*N+j)*DATA_W +: DATA_W]`; w[j][c] uses the same layout.
  - b[c] sits at `b_dout[c*ACC_W +: ACC_W]`.
  - An output word holds row i, with out[i][c] at `[c*ACC_W +: ACC_W]`.
- **Addresses**, for tile (r,c), step k, mode m:
  - A: `r*K_T + k`
  - W: `m*K_T*COLS_T + k*COLS_T + c`
  - bias: `m*COLS_T + c`
  - out: `(m*ROWS_T*COLS_T + r*COLS_T + c)*N + i`
- **Arithmetic**
  - acc[i][c] = b[c] + Σ_k Σ_j a[i][j]·w[j][c].
  - Products are sign-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W with no saturation.
- **Tile order**: c is the inner loop, then r.
- **SRAM read latency**: 1 cycle. Data is valid the cycle after `*_ceb`=0.
- **FSM**: IDLE → PRIME → ACC → WRITE → (PRIME | DONE) → IDLE.
  - **IDLE**: all `*_ceb`=1. On `start` with a legal mode, latch the mode and clear the counters.
  - **PRIME** (1 cycle): issue the bias read and the k=0 A/W reads.
  - **ACC** (K_T cycles):
    - On the first cycle, acc = bias + product.
    - On later cycles, acc += product.
    - Issue the k+1 reads while k < K_T−1.
  - **WRITE** (N cycles): write row i with `out_ceb`=`out_wen`=0.
    - Advance c, then r.
    - After the last tile, go to DONE.
  - **DONE** (1 cycle): `done`=1, then IDLE.
- `start` while busy is ignored; there is no queueing and no error.
- `rst` low in any state:
  - next cycle: IDLE, counters 0;
  - all `*_ceb`=1, `out_wen`=1;
  - `busy`=`done`=`err`=0.
  - Partial outputs already written remain.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `err`=0;
  - all `*_ceb`=1, `out_wen`=1;
  - all addresses 0, `out_din`=0.
- Accept at cycle 0 puts PRIME at cycle 1.
- Per tile: 1 + K_T + N cycles.
- `done` occurs at cycle 1 + ROWS_T·COLS_T·(1+K_T+N).
- Back-to-back: `start` sampled in the cycle after `done` is accepted.
- `out_din` and `out_addr` are registered and driven in the same cycle as `out_ceb`=0.

## Structure
- Package `proj_pkg`:
  - state enum `proj_state_t`;
  - mode constants `MODE_Q/K/V`;
  - helper functions for packed-field indexing.
- Sub-module `mac_tile`:
  - combinational N×N×N signed dot-product array, with a registered accumulator and a bias load;
  - `clear_load`/`acc_en` controls;
  - instantiated once.
- The engine holds only the FSM, counters and address generation.

## Test plan
1. **Basic Q tile**: N=4, ROWS_T=COLS_T=1, K_T=1, mode=0, A=identity, W=all 2, bias c=0..3 = {1,2,3,4}. Expect four writes at addr 0..3, each row {3,4,5,6}, and `done` at cycle 7.
2. **Reduction plus signed values**: K_T=2, A all −1, W all 127, bias 0. Expect every element −1016 (2·4·−127).
3. **Mode offset**: mode=2, ROWS_T=1, COLS_T=2, K_T=2.
   - W addresses start at 8; bias addresses are 4,5; out addresses are 16..23.
   - Expect `done` at cycle 15.
4. **Wrap**: ACC_W=16 build, sum reaching 40000. Expect 40000−65536 = −25536 written.
5. **Handshakes**:
   - mode=3 gives an `err` pulse with `busy` staying 0.
   - `start` at cycle 3 of a run is ignored.
   - `start` the cycle after `done` is accepted.
6. **Reset mid-run**: `rst`=0 during WRITE row 1. Next cycle all `ceb`=1 and `busy`=0; a fresh `start` reproduces scenario 1 exactly.

Source files
------------

// File: rtl/proj_pkg.sv
// proj_pkg: shared types and helpers for the QKV projection engine.
// FSM state enum, projection mode codes and packed-field indexing.
package proj_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ACC,
    S_WRITE,
    S_DONE
  } proj_state_t;

  localparam logic [1:0] MODE_Q = 2'd0;
  localparam logic [1:0] MODE_K = 2'd1;
  localparam logic [1:0] MODE_V = 2'd2;

  // bits needed to hold indices 0..v-1 (at least one)
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // lsb of element [i][j] in a row-major n-wide packed matrix
  function automatic int el_lsb(
    input int i,
    input int j,
    input int n,
    input int w
  );
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/mac_tile.sv
// mac_tile: N x N x N signed dot-product array with accumulator.
// clear_load seeds with bias + product; acc_en adds the product.
module mac_tile
  import proj_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_load,
  input  logic                    acc_en,
  input  logic [N*N*DATA_W-1:0]   a_vec,
  input  logic [N*N*DATA_W-1:0]   w_vec,
  input  logic [N*ACC_W-1:0]      b_vec,
  output logic [N*N*ACC_W-1:0]    acc_nx
);

  logic [N*N*ACC_W-1:0] dot;
  logic [N*N*ACC_W-1:0] acc_q;

  // dot[i][c] = sum_j a[i][j] * w[j][c], wrapping at ACC_W
  always_comb begin
    logic signed [ACC_W-1:0]    s;
    logic signed [2*DATA_W-1:0] p;
    dot = '0;
    s   = '0;
    p   = '0;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int j = 0; j < N; j++) begin
          p = $signed(a_vec[el_lsb(i, j, N, DATA_W) +: DATA_W])
            * $signed(w_vec[el_lsb(j, c, N, DATA_W) +: DATA_W]);
          s = s + ACC_W'(p);
        end
        dot[el_lsb(i, c, N, ACC_W) +: ACC_W] = s;
      end
    end
  end

  // next accumulator value: load, accumulate or hold
  always_comb begin
    int idx;
    idx    = 0;
    acc_nx = acc_q;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < N; c++) begin
        idx = el_lsb(i, c, N, ACC_W);
        if (clear_load) begin
          acc_nx[idx +: ACC_W] =
            b_vec[c*ACC_W +: ACC_W] + dot[idx +: ACC_W];
        end else if (acc_en) begin
          acc_nx[idx +: ACC_W] =
            acc_q[idx +: ACC_W] + dot[idx +: ACC_W];
        end
      end
    end
  end

  // accumulator register
  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_nx;
  end

endmodule

// File: rtl/qkv_proj_engine.sv
// qkv_proj_engine: tiled INT8 OUT = A x W[mode] + bias[mode].
// FSM, tile counters and SRAM address generation around mac_tile.
module qkv_proj_engine
  import proj_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS_T = 1,
  parameter int K_T    = 32,
  parameter int COLS_T = 32,
  parameter int IA_W   = cw(ROWS_T * K_T),
  parameter int W_AW   = cw(3 * K_T * COLS_T),
  parameter int B_AW   = cw(3 * COLS_T),
  parameter int O_AW   = cw(3 * ROWS_T * COLS_T * N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  in_ceb,
  output logic [IA_W-1:0]       in_addr,
  input  logic [N*N*DATA_W-1:0] in_dout,
  output logic                  w_ceb,
  output logic [W_AW-1:0]       w_addr,
  input  logic [N*N*DATA_W-1:0] w_dout,
  output logic                  b_ceb,
  output logic [B_AW-1:0]       b_addr,
  input  logic [N*ACC_W-1:0]    b_dout,
  output logic                  out_ceb,
  output logic                  out_wen,
  output logic [O_AW-1:0]       out_addr,
  output logic [N*ACC_W-1:0]    out_din
);

  localparam int RW = cw(ROWS_T);
  localparam int KW = cw(K_T);
  localparam int CW = cw(COLS_T);
  localparam int IW = cw(N);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS_T - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_T - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS_T - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);

  proj_state_t state_q, state_d;
  logic [1:0]    mode_q;
  logic [RW-1:0] r_q;
  logic [KW-1:0] k_q, k_rd;
  logic [CW-1:0] c_q;
  logic [IW-1:0] i_q, i_d;
  logic legal, accept, err_q;
  logic rd_en, b_en, clear_load, acc_en;
  logic [N*N*ACC_W-1:0] acc_nx;

  assign legal  = mode inside {MODE_Q, MODE_K, MODE_V};
  assign accept = start && legal && (state_q == S_IDLE);

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign in_ceb = !rd_en;
  assign w_ceb  = !rd_en;
  assign b_ceb  = !b_en;

  assign in_addr = IA_W'(int'(r_q) * K_T + int'(k_rd));
  assign w_addr  = W_AW'((int'(mode_q) * K_T + int'(k_rd))
                 * COLS_T + int'(c_q));
  assign b_addr  = B_AW'(int'(mode_q) * COLS_T + int'(c_q));

  mac_tile #(
    .N      (N),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clear_load (clear_load),
    .acc_en     (acc_en),
    .a_vec      (in_dout),
    .w_vec      (w_dout),
    .b_vec      (b_dout),
    .acc_nx     (acc_nx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next state, read strobes and MAC controls
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    b_en       = 1'b0;
    clear_load = 1'b0;
    acc_en     = 1'b0;
    k_rd       = '0;
    i_d        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_PRIME;
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        b_en    = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_en     = 1'b1;
        clear_load = (k_q == '0);
        rd_en      = (k_q != K_LAST);
        k_rd       = k_q + 1'b1;
        if (k_q == K_LAST) state_d = S_WRITE;
      end
      S_WRITE: begin
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) begin
          if (r_q == R_LAST && c_q == C_LAST)
            state_d = S_DONE;
          else
            state_d = S_PRIME;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // mode latch and k / row / tile counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= '0;
      r_q    <= '0;
      c_q    <= '0;
      k_q    <= '0;
      i_q    <= '0;
    end else if (accept) begin
      mode_q <= mode;
      r_q    <= '0;
      c_q    <= '0;
      k_q    <= '0;
      i_q    <= '0;
    end else if (state_q == S_ACC) begin
      k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
    end else if (state_q == S_WRITE) begin
      i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
      if (i_q == I_LAST) begin
        if (c_q == C_LAST) begin
          c_q <= '0;
          r_q <= (r_q == R_LAST) ? '0 : r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  // registered output-SRAM port and error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q    <= 1'b0;
      out_ceb  <= 1'b1;
      out_wen  <= 1'b1;
      out_addr <= '0;
      out_din  <= '0;
    end else begin
      err_q   <= start && !legal && (state_q == S_IDLE);
      out_ceb <= (state_d != S_WRITE);
      out_wen <= (state_d != S_WRITE);
      if (state_d == S_WRITE) begin
        out_addr <= O_AW'(((int'(mode_q) * ROWS_T + int'(r_q))
                  * COLS_T + int'(c_q)) * N + int'(i_d));
        out_din  <= acc_nx[int'(i_d)*N*ACC_W +: N*ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_qkv_proj_engine.sv
// tb_qkv_proj_engine: random and directed tiles vs. a matrix model.
// SRAMs are modelled as arrays with one-cycle read latency.
module tb_qkv_proj_engine;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int RT   = 2;
  localparam int KT   = 2;
  localparam int CT   = 2;
  localparam int IAW  = 2;
  localparam int WAW  = 4;
  localparam int BAW  = 3;
  localparam int OAW  = 6;
  localparam int DONE_T = 1 + RT * CT * (1 + KT + N);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy, done, err;
  logic in_ceb, w_ceb, b_ceb, out_ceb, out_wen;
  logic [IAW-1:0] in_addr;
  logic [WAW-1:0] w_addr;
  logic [BAW-1:0] b_addr;
  logic [OAW-1:0] out_addr;
  logic [N*N*DW-1:0] in_dout, w_dout;
  logic [N*AW-1:0] b_dout, out_din;

  logic [N*N*DW-1:0] a_mem [RT*KT];
  logic [N*N*DW-1:0] w_mem [3*KT*CT];
  logic [N*AW-1:0]   b_mem [3*CT];
  logic [N*AW-1:0]   o_mem [3*RT*CT*N];
  int wq[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qkv_proj_engine #(
    .N(N), .DATA_W(DW), .ACC_W(AW),
    .ROWS_T(RT), .K_T(KT), .COLS_T(CT),
    .IA_W(IAW), .W_AW(WAW), .B_AW(BAW), .O_AW(OAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .in_ceb(in_ceb), .in_addr(in_addr), .in_dout(in_dout),
    .w_ceb(w_ceb), .w_addr(w_addr), .w_dout(w_dout),
    .b_ceb(b_ceb), .b_addr(b_addr), .b_dout(b_dout),
    .out_ceb(out_ceb), .out_wen(out_wen),
    .out_addr(out_addr), .out_din(out_din)
  );

  // SRAM models
  always @(posedge clk) begin
    if (!in_ceb) in_dout <= a_mem[in_addr];
    if (!w_ceb)  w_dout  <= w_mem[w_addr];
    if (!b_ceb)  b_dout  <= b_mem[b_addr];
    if (!out_ceb && !out_wen) begin
      o_mem[out_addr] <= out_din;
      wq.push_back(int'(out_addr));
    end
  end

  function automatic int oaddr(int m, int r, int c, int i);
    return (m * RT * CT + r * CT + c) * N + i;
  endfunction

  // row i of tile (r,c): bias + sum over k,j of a*w, mod 2^AW
  function automatic logic [N*AW-1:0] model_row(
    int m, int r, int c, int i);
    logic [N*AW-1:0] row;
    logic [N*N*DW-1:0] aw, ww;
    logic [AW-1:0] bv;
    logic signed [DW-1:0] av, wv;
    logic signed [31:0] s;
    row = '0;
    for (int cc = 0; cc < N; cc++) begin
      bv = b_mem[m*CT + c][cc*AW +: AW];
      s = {{(32-AW){bv[AW-1]}}, bv};
      for (int k = 0; k < KT; k++) begin
        aw = a_mem[r*KT + k];
        ww = w_mem[m*KT*CT + k*CT + c];
        for (int j = 0; j < N; j++) begin
          av = aw[(i*N + j)*DW +: DW];
          wv = ww[(j*N + cc)*DW +: DW];
          s = s + av * wv;
        end
      end
      row[cc*AW +: AW] = s[AW-1:0];
    end
    return row;
  endfunction

  function automatic int rows_bad(int m);
    int bad = 0;
    int a;
    logic [N*AW-1:0] e;
    for (int r = 0; r < RT; r++)
      for (int c = 0; c < CT; c++)
        for (int i = 0; i < N; i++) begin
          a = oaddr(m, r, c, i);
          e = model_row(m, r, c, i);
          if (o_mem[a] !== e) begin
            bad++;
            if (bad == 1)
              $display("  addr %0d got %h exp %h", a, o_mem[a], e);
          end
        end
    return bad;
  endfunction

  function automatic int const_bad(int m, logic [AW-1:0] v);
    int bad = 0;
    logic [N*AW-1:0] e;
    e = {N{v}};
    for (int r = 0; r < RT; r++)
      for (int c = 0; c < CT; c++)
        for (int i = 0; i < N; i++)
          if (o_mem[oaddr(m, r, c, i)] !== e) bad++;
    return bad;
  endfunction

  // write order: c inner, then r; rows i within a tile
  function automatic int order_bad(int m);
    int bad = 0;
    int n = 0;
    for (int r = 0; r < RT; r++)
      for (int c = 0; c < CT; c++)
        for (int i = 0; i < N; i++) begin
          if (n >= wq.size() || wq[n] != oaddr(m, r, c, i)) bad++;
          n++;
        end
    if (wq.size() != n) bad++;
    return bad;
  endfunction

  task automatic fill_random();
    foreach (a_mem[x])
      for (int b = 0; b < N*N; b++) a_mem[x][b*DW +: DW] = DW'($urandom);
    foreach (w_mem[x])
      for (int b = 0; b < N*N; b++) w_mem[x][b*DW +: DW] = DW'($urandom);
    foreach (b_mem[x])
      for (int b = 0; b < N; b++) b_mem[x][b*AW +: AW] = AW'($urandom);
  endtask

  task automatic fill_const(logic [DW-1:0] av, logic [DW-1:0] wv,
                            logic [AW-1:0] bv);
    foreach (a_mem[x]) a_mem[x] = {N*N{av}};
    foreach (w_mem[x]) w_mem[x] = {N*N{wv}};
    foreach (b_mem[x]) b_mem[x] = {N{bv}};
  endtask

  task automatic clear_out();
    foreach (o_mem[x]) o_mem[x] = 'x;
  endtask

  // caller is at a negedge; start is sampled at the next posedge
  task automatic run_job(input logic [1:0] m, input int inj,
                         output int dt, output int bb);
    dt = -1;
    bb = 0;
    wq.delete();
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 400 && dt < 0; t++) begin
      if (t > 1) @(negedge clk);
      if (busy !== 1'b1) bb++;
      if (done === 1'b1) dt = t;
      if (t == inj) begin
        start = 1'b1;
        mode  = 2'd1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0) bb++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, err, in_ceb, w_ceb, b_ceb, out_ceb, out_wen}
        !== 8'b00011111) begin
      n_fail++;
      $display("FAIL reset_ctl got %b need 00011111",
        {busy, done, err, in_ceb, w_ceb, b_ceb, out_ceb, out_wen});
    end
    n_tests++;
    if ({in_addr, w_addr, b_addr, out_addr, out_din} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr got %h need 0",
        {in_addr, w_addr, b_addr, out_addr, out_din});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd3;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({err, busy, in_ceb} !== 3'b101) begin
      n_fail++;
      $display("FAIL illegal_err got err/busy/ceb %b need 101",
        {err, busy, in_ceb});
    end
    @(negedge clk);
    n_tests++;
    if ({err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_pulse got err/busy %b need 00", {err, busy});
    end
  endtask

  task automatic test_modes();
    int dt, bb, nb;
    for (int m = 0; m < 3; m++) begin
      repeat (2) begin
        fill_random();
        clear_out();
        @(negedge clk);
        run_job(2'(m), -1, dt, bb);
        n_tests++;
        if (dt !== DONE_T) begin
          n_fail++;
          $display("FAIL mode%0d_done got %0d need %0d", m, dt, DONE_T);
        end
        n_tests++;
        if (bb !== 0) begin
          n_fail++;
          $display("FAIL mode%0d_busy got %0d bad cycles need 0", m, bb);
        end
        nb = order_bad(m);
        n_tests++;
        if (nb !== 0) begin
          n_fail++;
          $display("FAIL mode%0d_order got %0d bad addrs need 0", m, nb);
        end
        nb = rows_bad(m);
        n_tests++;
        if (nb !== 0) begin
          n_fail++;
          $display("FAIL mode%0d_data got %0d bad rows need 0", m, nb);
        end
      end
    end
  endtask

  task automatic test_signed();
    int dt, bb, nb;
    fill_const(8'hFF, 8'h7F, 16'h0000);
    clear_out();
    @(negedge clk);
    run_job(2'd0, -1, dt, bb);
    nb = const_bad(0, 16'hFC08);
    n_tests++;
    if (nb !== 0 || dt !== DONE_T) begin
      n_fail++;
      $display("FAIL signed_sum got %0d bad rows done %0d need 0 / %0d",
        nb, dt, DONE_T);
    end
  endtask

  task automatic test_wrap();
    int dt, bb, nb;
    fill_const(8'd100, 8'd50, 16'h0000);
    clear_out();
    @(negedge clk);
    run_job(2'd1, -1, dt, bb);
    nb = const_bad(1, 16'h9C40);
    n_tests++;
    if (nb !== 0) begin
      n_fail++;
      $display("FAIL wrap got %0d bad rows need 0 (-25536)", nb);
    end
  endtask

  task automatic test_busy_start();
    int dt, bb, nb;
    fill_random();
    clear_out();
    @(negedge clk);
    run_job(2'd0, 3, dt, bb);
    n_tests++;
    if (dt !== DONE_T || bb !== 0) begin
      n_fail++;
      $display("FAIL busy_start got done %0d bad %0d need %0d / 0",
        dt, bb, DONE_T);
    end
    nb = rows_bad(0) + order_bad(0);
    n_tests++;
    if (nb !== 0) begin
      n_fail++;
      $display("FAIL busy_start_data got %0d errors need 0", nb);
    end
  endtask

  task automatic test_back_to_back();
    int dt1, dt2, bb1, bb2, nb;
    fill_random();
    clear_out();
    @(negedge clk);
    run_job(2'd1, -1, dt1, bb1);
    run_job(2'd2, -1, dt2, bb2);
    n_tests++;
    if (dt1 !== DONE_T || dt2 !== DONE_T) begin
      n_fail++;
      $display("FAIL b2b_done got %0d,%0d need %0d", dt1, dt2, DONE_T);
    end
    nb = rows_bad(1) + rows_bad(2) + order_bad(2);
    n_tests++;
    if (nb !== 0 || bb1 !== 0 || bb2 !== 0) begin
      n_fail++;
      $display("FAIL b2b_data got %0d errors busy %0d/%0d need 0",
        nb, bb1, bb2);
    end
  endtask

  task automatic test_reset_mid();
    int dt, bb, nb;
    fill_random();
    clear_out();
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    // cycles: PRIME 1, ACC 2..3, WRITE rows 0..3 at 4..7
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++;
    if ({busy, out_ceb, out_addr} !== {1'b1, 1'b0, 6'd1}) begin
      n_fail++;
      $display("FAIL mid_row1 got busy %b ceb %b addr %0d need 1 0 1",
        busy, out_ceb, out_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, in_ceb, w_ceb, b_ceb, out_ceb, out_wen}
        !== 7'b0011111) begin
      n_fail++;
      $display("FAIL mid_reset got %b need 0011111",
        {busy, done, in_ceb, w_ceb, b_ceb, out_ceb, out_wen});
    end
    n_tests++;
    if (wq.size() !== 2) begin
      n_fail++;
      $display("FAIL mid_partial got %0d writes need 2", wq.size());
    end
    rst = 1'b1;
    clear_out();
    @(negedge clk);
    run_job(2'd0, -1, dt, bb);
    nb = rows_bad(0) + order_bad(0);
    n_tests++;
    if (nb !== 0 || dt !== DONE_T || bb !== 0) begin
      n_fail++;
      $display("FAIL mid_rerun got %0d errors done %0d need 0 / %0d",
        nb, dt, DONE_T);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_modes();
    test_signed();
    test_wrap();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
